// File: rtl/rvfi_retire_buffer.sv
// Multi-retire RVFI trace collector: stamps up to NRET retirements per cycle with a
// 64-bit order, buffers them in a circular FIFO and replays them one per cycle.
module rvfi_retire_buffer #(
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NRET-1:0]          ret_valid,
  input  logic [32*NRET-1:0]       ret_insn,
  input  logic [NRET-1:0]          ret_trap,
  input  logic [32*NRET-1:0]       ret_pc_rdata,
  input  logic [32*NRET-1:0]       ret_pc_wdata,
  input  logic [5*NRET-1:0]        ret_rd_addr,
  input  logic [32*NRET-1:0]       ret_rd_wdata,
  input  logic [32*NRET-1:0]       ret_mem_addr,
  input  logic [4*NRET-1:0]        ret_mem_rmask,
  input  logic [4*NRET-1:0]        ret_mem_wmask,
  input  logic [32*NRET-1:0]       ret_mem_rdata,
  input  logic [32*NRET-1:0]       ret_mem_wdata,
  input  logic                     rvfi_ready,
  output logic                     rvfi_valid,
  output logic [63:0]              rvfi_order,
  output logic [31:0]              rvfi_insn,
  output logic                     rvfi_trap,
  output logic [31:0]              rvfi_pc_rdata,
  output logic [31:0]              rvfi_pc_wdata,
  output logic [4:0]               rvfi_rd_addr,
  output logic [31:0]              rvfi_rd_wdata,
  output logic [31:0]              rvfi_mem_addr,
  output logic [3:0]               rvfi_mem_rmask,
  output logic [3:0]               rvfi_mem_wmask,
  output logic [31:0]              rvfi_mem_rdata,
  output logic [31:0]              rvfi_mem_wdata,
  output logic [1:0]               rvfi_mode,
  output logic [1:0]               rvfi_ixl,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rec_t;

  rec_t          r_mem [DEPTH];
  logic [LW-1:0] r_head;
  logic [LW-1:0] r_tail;
  logic [63:0]   r_order_ctr;
  logic          r_overflow;

  logic [LW-1:0] w_level;
  logic [LW-1:0] w_free;
  logic [LW-1:0] w_cnt;
  logic [LW-1:0] w_npush;
  logic [NRET-1:0] w_accept;
  logic [AW-1:0] w_wslot [NRET];
  rec_t          w_rec [NRET];
  logic          w_pop;
  logic          w_drop;
  rec_t          w_head;

  // Rank each valid channel among this cycle's retirements; rank drives both the
  // order stamp and the write slot, and ranks at or beyond the pre-pop free space drop.
  always_comb begin
    w_level  = r_tail - r_head;
    w_free   = DEPTH_L - w_level;
    w_cnt    = '0;
    w_npush  = '0;
    w_accept = '0;
    for (int i = 0; i < NRET; i++) begin
      w_wslot[i]            = AW'(r_tail + w_cnt);
      w_rec[i].order        = r_order_ctr + 64'(w_cnt);
      w_rec[i].insn         = ret_insn[32*i +: 32];
      w_rec[i].trap         = ret_trap[i];
      w_rec[i].pc_rdata     = ret_pc_rdata[32*i +: 32];
      w_rec[i].pc_wdata     = ret_pc_wdata[32*i +: 32];
      w_rec[i].rd_addr      = ret_rd_addr[5*i +: 5];
      w_rec[i].rd_wdata     = (ret_rd_addr[5*i +: 5] == 5'd0) ? 32'd0 : ret_rd_wdata[32*i +: 32];
      w_rec[i].mem_addr     = ret_mem_addr[32*i +: 32];
      w_rec[i].mem_rmask    = ret_mem_rmask[4*i +: 4];
      w_rec[i].mem_wmask    = ret_mem_wmask[4*i +: 4];
      w_rec[i].mem_rdata    = ret_mem_rdata[32*i +: 32];
      w_rec[i].mem_wdata    = ret_mem_wdata[32*i +: 32];
      w_accept[i]           = ret_valid[i] && (w_cnt < w_free);
      if (w_accept[i]) w_npush = w_npush + LW'(1);
      if (ret_valid[i]) w_cnt = w_cnt + LW'(1);
    end
    w_drop = (w_npush != w_cnt);
  end

  assign w_pop  = rvfi_valid && rvfi_ready;
  assign w_head = r_mem[r_head[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_order_ctr <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_tail      <= r_tail + w_npush;
      if (w_pop) r_head <= r_head + LW'(1);
      r_order_ctr <= r_order_ctr + 64'(w_cnt);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NRET; i++) begin
      if (w_accept[i]) r_mem[w_wslot[i]] <= w_rec[i];
    end
  end

  always_comb begin
    rvfi_valid     = (w_level != '0);
    rvfi_order     = '0;
    rvfi_insn      = '0;
    rvfi_trap      = 1'b0;
    rvfi_pc_rdata  = '0;
    rvfi_pc_wdata  = '0;
    rvfi_rd_addr   = '0;
    rvfi_rd_wdata  = '0;
    rvfi_mem_addr  = '0;
    rvfi_mem_rmask = '0;
    rvfi_mem_wmask = '0;
    rvfi_mem_rdata = '0;
    rvfi_mem_wdata = '0;
    if (rvfi_valid) begin
      rvfi_order     = w_head.order;
      rvfi_insn      = w_head.insn;
      rvfi_trap      = w_head.trap;
      rvfi_pc_rdata  = w_head.pc_rdata;
      rvfi_pc_wdata  = w_head.pc_wdata;
      rvfi_rd_addr   = w_head.rd_addr;
      rvfi_rd_wdata  = w_head.rd_wdata;
      rvfi_mem_addr  = w_head.mem_addr;
      rvfi_mem_rmask = w_head.mem_rmask;
      rvfi_mem_wmask = w_head.mem_wmask;
      rvfi_mem_rdata = w_head.mem_rdata;
      rvfi_mem_wdata = w_head.mem_wdata;
    end
  end

  assign rvfi_mode = 2'b11;
  assign rvfi_ixl  = 2'b01;
  assign overflow  = r_overflow;
  assign level     = w_level;

endmodule

// File: doc/rvfi_retire_buffer.md
# rvfi_retire_buffer

Parametrised RVFI trace collector for Sodor-class cores. It accepts up to NRET retirement records per cycle from the core's commit logic and stamps each with a monotonically increasing 64-bit order. Records are held in a DEPTH-entry FIFO and presented one per cycle on a single RVFI channel with consumer backpressure. It sits between the core's retire-tracking registers and the formal/contract checker, replacing per-core ad-hoc single-retire RVFI wiring.

## Interface
- NRET, 2: retire channels per cycle, 1..4.
- DEPTH, 8: FIFO entries, power of 2, ≥ NRET.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- ret_valid  in  NRET  per-channel retire strobe; channel 0 is oldest.
- ret_insn  in  32*NRET  instruction word, channel i at [32i+31:32i]; the same packing applies to all per-channel buses.
- ret_trap  in  NRET  instruction trapped.
- ret_pc_rdata, ret_pc_wdata  in  32*NRET  PC of instruction / next PC.
- ret_rd_addr  in  5*NRET  destination register.
- ret_rd_wdata  in  32*NRET  value written to rd.
- ret_mem_addr, ret_mem_rdata, ret_mem_wdata  in  32*NRET  memory access fields.
- ret_mem_rmask, ret_mem_wmask  in  4*NRET  byte masks.
- rvfi_ready  in  1  consumer accepts the head record.
- rvfi_valid  out  1  head record present.
- rvfi_order  out  64  order stamp of head record.
- rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata  out  (as inputs)  head record fields.
- rvfi_mode  out  2  constant 2'b11 (M-mode).
- rvfi_ixl  out  2  constant 2'b01.
- overflow  out  1  sticky: a record was dropped.
- level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Enqueue order: valid channels are packed in ascending channel index, with invalid channels skipped. The k-th valid channel (k from 0) is stamped with order_ctr + k.
- order_ctr advances by popcount(ret_valid) every cycle, including dropped records, so a gap in rvfi_order exposes a drop. It is 64-bit and wraps modulo 2^64.
- Capacity check: free = DEPTH − level, using level before this cycle's pop. There is no same-cycle reuse of a freed slot. If popcount > free, the first `free` valid records in channel order are written, the rest are discarded, and overflow is set. overflow clears only on reset.
- Dequeue: a pop occurs when rvfi_valid && rvfi_ready. rvfi_ready while empty has no effect.
- Sanitising: when ret_rd_addr == 0, the stored rd_wdata is 0 regardless of input. rvfi_mem_* are passed unmodified.
- Storage is a circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping at DEPTH. level = tail − head using one extra wrap bit.
- Outputs are driven combinationally from the head entry. When rvfi_valid = 0, all rvfi_* data outputs read 0, except rvfi_mode and rvfi_ixl, which stay constant.

## Timing
- Reset: applied on the clock edge while reset = 1.
  - Clears head, tail, order_ctr, and overflow.
  - rvfi_valid = 0, level = 0, all rvfi data outputs 0.
  - Any ret_valid in the reset cycle is ignored and does not advance order_ctr.
  - Reset mid-stream discards all buffered records.
- Latency: a record presented at edge t appears on rvfi_* after edge t (visible in cycle t+1) if the FIFO was empty. There is no combinational bypass from ret_* to rvfi_*.
- Simultaneous push and pop: both happen. level changes by pushes − 1.
- Full with pop and NRET valid: only free (pre-pop) slots are accepted. Example: level = DEPTH, pop=1, push of 2 → 0 written, overflow=1, level = DEPTH−1.
- Throughput: 1 record/cycle out and up to NRET in. Sustained input above 1/cycle with rvfi_ready = 1 eventually overflows, by design.

## Test plan
- Reset, then a single record on channel 0 (insn=0x00500093, pc 0x80000000→0x80000004, rd=1, wdata=5) with rvfi_ready=1 → the next cycle shows rvfi_valid=1, order=0, fields equal to the input; the cycle after shows valid=0 and level=0.
- NRET=2, ret_valid=2'b11 for 3 cycles with rvfi_ready=0 → level=6 and the head shows order 0. Then set ready=1 → orders 0,1,2,3,4,5 stream out on consecutive cycles.
- ret_valid=2'b10 only → the record is stamped with order_ctr, matching the channel-0-only case. Records with rd_addr=0 and wdata=0xDEADBEEF → rvfi_rd_wdata=0.
- DEPTH=8, fill to level=7, then push 2 in one cycle with ready=0 → channel 0 is stored, channel 1 is dropped, overflow=1, level=8. The next accepted record's order jumps by 2 past the last stored one.
- Preload order_ctr near 2^64−1 (via 2^64−1 pushes modelled by a force, or a DEPTH=1 long run) → order wraps to 0 without disturbing the FIFO.
- Assert reset while level=5 and the valid head is being popped → the next cycle shows level=0, rvfi_valid=0, overflow=0, and the next record is stamped order=0.
